// File: rtl/mamba2_pkg.sv
// Shared definitions for the mamba2 datapath blocks: element width, reader FSM
// encoding, flat (b,h,p) indexing and index-width helper.
package mamba2_pkg;

  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } dx_state_e;

  // Flat element index in (b,h,p) order.
  function automatic int unsigned flat_idx(input int unsigned b, input int unsigned h,
                                           input int unsigned p, input int unsigned hn,
                                           input int unsigned pn);
    return b * hn * pn + h * pn + p;
  endfunction

  // Bits needed to index n items, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dx_result_reader.sv
// Starts one dx computation, snapshots its flat result and streams it out LANES
// elements per beat. Optional WAIT watchdog: define DX_READER_TIMEOUT_EN.
module dx_result_reader
  import mamba2_pkg::*;
#(
  parameter int unsigned B           = 1,
  parameter int unsigned H           = 4,
  parameter int unsigned P           = 4,
  parameter int unsigned DW          = DW_DEFAULT,
  parameter int unsigned LANES       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IW         = clog2_min1(B * H * P)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  output logic                    busy,
  output logic                    dx_start,
  input  logic                    dx_done,
  input  logic [B*H*P*DW-1:0]     dx_flat,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*DW-1:0]     m_data,
  output logic [IW-1:0]           m_idx,
  output logic                    m_last,
  output logic                    timeout
);

  localparam int unsigned NELEM  = B * H * P;
  localparam int unsigned NBEATS = NELEM / LANES;
  localparam int unsigned BW     = clog2_min1(NBEATS);
  localparam int unsigned BEAT_W = LANES * DW;

  if ((NELEM % LANES) != 0) begin : g_bad_lanes
    $error("dx_result_reader: B*H*P must be divisible by LANES");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("dx_result_reader: TIMEOUT_CYC must be at least 1");
  end

  dx_state_e             state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d, beat_nx_c;
  logic [NELEM*DW-1:0]   buf_q;
  logic [BEAT_W-1:0]     beat_sel_c;
  logic                  busy_d, dx_start_d, m_valid_d, m_last_d;
  logic [BEAT_W-1:0]     m_data_d;
  logic [IW-1:0]         m_idx_d;
  logic                  tmo_hit_c;

  assign beat_nx_c  = beat_q + BW'(1);
  assign beat_sel_c = buf_q[32'(beat_nx_c) * BEAT_W +: BEAT_W];

  // Snapshot of the dx result; only written on the WAIT->STREAM capture.
  always_ff @(posedge clk) begin
    if (state_q == ST_WAIT && dx_done) buf_q <= dx_flat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      busy     <= 1'b0;
      dx_start <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      m_idx    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      busy     <= busy_d;
      dx_start <= dx_start_d;
      m_valid  <= m_valid_d;
      m_last   <= m_last_d;
      m_data   <= m_data_d;
      m_idx    <= m_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    dx_start_d = 1'b0;
    m_valid_d  = m_valid;
    m_last_d   = m_last;
    m_data_d   = m_data;
    m_idx_d    = m_idx;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_WAIT;
          dx_start_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Beat 0 comes straight from the bus since the buffer loads on this edge.
        if (dx_done) begin
          state_d   = ST_STREAM;
          beat_d    = '0;
          m_valid_d = 1'b1;
          m_data_d  = dx_flat[BEAT_W-1:0];
          m_idx_d   = '0;
          m_last_d  = (NBEATS == 1);
        end else if (tmo_hit_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (m_valid && m_ready) begin
          if (m_last) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            beat_d   = beat_nx_c;
            m_data_d = beat_sel_c;
            m_idx_d  = IW'(32'(beat_nx_c) * LANES);
            m_last_d = (beat_nx_c == BW'(NBEATS - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef DX_READER_TIMEOUT_EN
  localparam int unsigned TW = clog2_min1(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt_q;

  // A done on the expiry cycle takes priority over the watchdog.
  assign tmo_hit_c = (state_q == ST_WAIT) && !dx_done &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= tmo_hit_c;
      if (state_q == ST_WAIT && state_d == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + TW'(1);
      else                                          tmo_cnt_q <= '0;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_dx_result_reader.sv
// Scoreboard bench for dx_result_reader: default build plus a B=2/LANES=8 instance.
module tb_dx_result_reader;

  typedef struct {
    logic [127:0] data;
    int           idx;
    logic         last;
  } beat_t;

  logic clk, rst;

  // Default-parameter DUT
  logic        req, busy, dx_start, dx_done, m_valid, m_ready, m_last, timeout;
  logic [255:0] dx_flat;
  logic [63:0] m_data;
  logic [3:0]  m_idx;

  // Sweep DUT: B=2, LANES=8
  logic        req2, busy2, dx_start2, dx_done2, m_valid2, m_ready2, m_last2, timeout2;
  logic [511:0] dx_flat2;
  logic [127:0] m_data2;
  logic [4:0]  m_idx2;

  int errors, checks;
  int start_cnt, hs_cnt, hs2_cnt, tmo_cnt, mv_cnt;
  beat_t sb[$];
  beat_t sb2[$];
  beat_t e, e2;
  logic        stall_q;
  logic [63:0] held_data;
  logic [3:0]  held_idx;
  logic        bp_en;

  dx_result_reader #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .dx_start(dx_start),
    .dx_done(dx_done), .dx_flat(dx_flat), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .timeout(timeout)
  );

  dx_result_reader #(.B(2), .LANES(8), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .busy(busy2), .dx_start(dx_start2),
    .dx_done(dx_done2), .dx_flat(dx_flat2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_idx(m_idx2), .m_last(m_last2), .timeout(timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Downstream ready: always 1, or alternating when backpressure is on.
  always @(posedge clk) begin
    #1;
    m_ready = bp_en ? ~m_ready : 1'b1;
  end

  // Monitor / scoreboard for the default DUT.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (dx_start) start_cnt++;
      if (timeout) tmo_cnt++;
      if (m_valid) mv_cnt++;
      if (stall_q && m_valid) begin
        chk("hold_data", 128'(m_data), 128'(held_data));
        chk("hold_idx", 128'(m_idx), 128'(held_idx));
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (sb.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat_data", 128'(m_data), e.data);
          chk("beat_idx", 128'(m_idx), 128'(e.idx));
          chk("beat_last", 128'(m_last), 128'(e.last));
        end
      end
      stall_q   = m_valid && !m_ready;
      held_data = m_data;
      held_idx  = m_idx;
    end
  end

  // Monitor / scoreboard for the sweep DUT.
  always @(negedge clk) begin
    if (!rst && m_valid2 && m_ready2) begin
      hs2_cnt++;
      if (sb2.size() == 0) chk("extra_beat2", 1, 0);
      else begin
        e2 = sb2.pop_front();
        chk("beat2_data", m_data2, e2.data);
        chk("beat2_idx", 128'(m_idx2), 128'(e2.idx));
        chk("beat2_last", 128'(m_last2), 128'(e2.last));
      end
    end
  end

  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  // Drive a done pulse with element g = base+g; optionally queue the expected frame.
  task automatic pulse_done(input logic [15:0] base, input bit push);
    beat_t b;
    @(posedge clk); #1;
    dx_done = 1'b1;
    for (int g = 0; g < 16; g++) dx_flat[g*16 +: 16] = base + 16'(g);
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        b.data = '0;
        for (int l = 0; l < 4; l++) b.data[l*16 +: 16] = base + 16'(k*4 + l);
        b.idx  = k * 4;
        b.last = (k == 3);
        sb.push_back(b);
      end
    end
    @(posedge clk); #1 dx_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(n < 80), 1);
  endtask

  initial begin
    int s0, first_at;
    beat_t b;
    errors = 0; checks = 0;
    start_cnt = 0; hs_cnt = 0; hs2_cnt = 0; tmo_cnt = 0; mv_cnt = 0;
    stall_q = 1'b0; bp_en = 1'b0; m_ready = 1'b1; m_ready2 = 1'b1;
    rst = 1'b1; req = 1'b0; dx_done = 1'b0; dx_flat = '0;
    req2 = 1'b0; dx_done2 = 1'b0; dx_flat2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_start", 128'(dx_start), 0);
    chk("rst_valid", 128'(m_valid), 0);
    chk("rst_last", 128'(m_last), 0);
    chk("rst_data", 128'(m_data), 0);
    chk("rst_idx", 128'(m_idx), 0);
    chk("rst_timeout", 128'(timeout), 0);

    // Basic frame, ready always high
    pulse_req();
    @(negedge clk);
    chk("basic_start_hi", 128'(dx_start), 1);
    chk("basic_busy", 128'(busy), 1);
    @(negedge clk);
    chk("basic_start_lo", 128'(dx_start), 0);
    repeat (7) @(posedge clk);
    pulse_done(16'h3C00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("basic_valid", 128'(m_valid), 1);
      if (k == 0) chk("basic_beat0", 128'(m_data), 128'(64'h3C03_3C02_3C01_3C00));
    end
    @(negedge clk);
    chk("basic_idle_busy", 128'(busy), 0);
    chk("basic_idle_valid", 128'(m_valid), 0);
    chk("basic_sb_empty", 128'(sb.size()), 0);
    chk("basic_start_cnt", 128'(start_cnt), 1);

    // Backpressure
    hs_cnt = 0;
    bp_en = 1'b1;
    pulse_req();
    repeat (3) @(posedge clk);
    pulse_done(16'h4000, 1'b1);
    wait_drain("bp_drain");
    chk("bp_handshakes", 128'(hs_cnt), 4);

    // Ignored req/done while busy
    hs_cnt = 0;
    s0 = start_cnt;
    pulse_req();
    pulse_req();
    pulse_done(16'h5000, 1'b1);
    pulse_req();
    pulse_done(16'h6000, 1'b0);
    wait_drain("ign_drain");
    chk("ign_start_cnt", 128'(start_cnt), 128'(s0 + 1));
    chk("ign_handshakes", 128'(hs_cnt), 4);
    bp_en = 1'b0;
    repeat (3) @(posedge clk);

    // Reset after the beat 1 handshake
    pulse_req();
    repeat (2) @(posedge clk);
    pulse_done(16'h7000, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstm_valid", 128'(m_valid), 0);
    chk("rstm_busy", 128'(busy), 0);
    chk("rstm_popped", 128'(sb.size()), 2);
    sb.delete();
    hs_cnt = 0;
    pulse_req();
    pulse_done(16'h7100, 1'b1);
    @(negedge clk);
    chk("rstm_restart_idx", 128'(m_idx), 0);
    wait_drain("rstm_drain");
    chk("rstm_handshakes", 128'(hs_cnt), 4);

    // Parameter sweep instance
    @(posedge clk); #1 req2 = 1'b1;
    @(posedge clk); #1 req2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 dx_done2 = 1'b1;
    for (int g = 0; g < 32; g++) dx_flat2[g*16 +: 16] = 16'h1000 + 16'(g);
    for (int k = 0; k < 4; k++) begin
      b.data = '0;
      for (int l = 0; l < 8; l++) b.data[l*16 +: 16] = 16'h1000 + 16'(k*8 + l);
      b.idx  = k * 8;
      b.last = (k == 3);
      sb2.push_back(b);
    end
    @(posedge clk); #1 dx_done2 = 1'b0;
    for (int n = 0; n < 40 && (sb2.size() != 0 || busy2); n++) @(negedge clk);
    chk("sweep_sb_empty", 128'(sb2.size()), 0);
    chk("sweep_handshakes", 128'(hs2_cnt), 4);
    chk("sweep_last_lane7", 128'(m_data2[127:112]), 128'(16'h101F));
    chk("sweep_idle", 128'(busy2), 0);

    // WAIT watchdog
    tmo_cnt = 0; mv_cnt = 0; first_at = 0;
    pulse_req();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout && first_at == 0) first_at = i;
    end
`ifdef DX_READER_TIMEOUT_EN
    chk("tmo_cycle", 128'(first_at), 17);
    chk("tmo_pulses", 128'(tmo_cnt), 1);
    chk("tmo_busy", 128'(busy), 0);
`else
    chk("tmo_none", 128'(tmo_cnt), 0);
    chk("tmo_hold_busy", 128'(busy), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
`endif
    chk("tmo_no_valid", 128'(mv_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
